pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge system clock.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port PCControl, input, 2 bits: 0 = Stall, 1 = Inc, 2 = CondLoad, 3 = reserved (treated as Stall).
REQ-004 SHALL have port JumpTaken, input, 1 bit: a jump-class instruction (j/jal/ret) is in the memory-access stage.
REQ-005 SHALL have port BranchTaken, input, 1 bit: a beq is in the memory-access stage with ALU zero set.
REQ-006 SHALL have port Call, input, 1 bit: the jump is a jal.
REQ-007 SHALL have port Return, input, 1 bit: the jump is a ret.
REQ-008 SHALL have port JumpAddr, input, 16 bits: jump target from EX/MEM.
REQ-009 SHALL have port BranchAddr, input, 16 bits: branch target from EX/MEM.
REQ-010 SHALL have port PC, output, 16 bits: current program counter (registered).
REQ-011 SHALL have port StackDepth, output, 3 bits: valid return-stack entries, 0..4.
REQ-012 SHALL have port StackOverflow, output, 1 bit: sticky flag, push at depth 4.
REQ-013 SHALL have port StackUnderflow, output, 1 bit: sticky flag, pop at depth 0.

Function
REQ-014 SHALL update PC, the stack and the flags only on the rising edge of clock; all outputs registered.
REQ-015 Stall (PCControl 0 or 3): PC, stack, depth and flags SHALL all hold.
REQ-016 Inc: PC SHALL become PC+2, modulo 2^16 (0xFFFE -> 0x0000); stack unchanged.
REQ-017 CondLoad: the action SHALL be chosen by priority Return > Jump > Branch > hold.
REQ-018 CondLoad, JumpTaken=1 and Return=1, depth>0: PC SHALL become the top stack entry; depth decrements.
REQ-019 CondLoad, JumpTaken=1 and Return=1, depth=0: PC SHALL hold, StackUnderflow SHALL set, depth stays 0.
REQ-020 CondLoad, JumpTaken=1 and Return=0: PC SHALL become JumpAddr.
REQ-021 Same case with Call=1: current PC (the already-incremented return address) SHALL be pushed in the same cycle.
REQ-022 Push at depth<4 SHALL increment depth.
REQ-023 Push at depth 4 SHALL overwrite the oldest entry (circular 4-entry buffer), keep depth at 4, and set StackOverflow.
REQ-024 CondLoad, JumpTaken=0 and BranchTaken=1: PC SHALL become BranchAddr.
REQ-025 CondLoad, JumpTaken=0 and BranchTaken=0: PC SHALL hold.
REQ-026 Call or Return SHALL be ignored when JumpTaken=0 or PCControl is not CondLoad.
REQ-027 Call=1 together with Return=1 SHALL be treated as a Return only (no push).
REQ-028 Bit 0 of every value loaded into PC (JumpAddr, BranchAddr, popped entry) SHALL be forced to 0.
REQ-029 StackOverflow and StackUnderflow SHALL stay set until reset.
REQ-030 Stack SHALL be implemented as a 4x16 array with a 2-bit top pointer plus the depth counter; no combinational path from any input to any output.

Reset
REQ-031 reset=1 at a clock edge SHALL set PC=0x0000, StackDepth=0, StackOverflow=0, StackUnderflow=0 and all stack entries to 0x0000.
REQ-032 reset SHALL take priority over every PCControl value, including mid-CondLoad.
REQ-033 Outputs SHALL be defined from the first edge with reset=1.

Verification
REQ-034 After reset, drive the controller sequence Inc, Stall, Stall, CondLoad with no taken flags, three times -> PC reads 0x0002, 0x0004, 0x0006; depth stays 0.
REQ-035 PC=0x0010; CondLoad with BranchTaken=1, BranchAddr=0x0041 -> PC=0x0040. Then CondLoad with JumpTaken=1, BranchTaken=1, JumpAddr=0x0100 -> PC=0x0100.
REQ-036 PC=0x0020; CondLoad with jal to 0x0200 -> PC=0x0200, depth 1, top entry=0x0020. Then CondLoad with ret -> PC=0x0020, depth 0.
REQ-037 Five nested jal calls from return addresses 0x02, 0x04, 0x06, 0x08, 0x0A -> depth 4, StackOverflow=1. Four rets then pop 0x0A, 0x08, 0x06, 0x04. A fifth ret -> PC holds, StackUnderflow=1.
REQ-038 PC=0xFFFE, Inc -> PC=0x0000.
REQ-039 Assert reset during a CondLoad jal -> PC=0, depth 0, both flags 0 on that edge; no push recorded.

Source files
------------

// File: rtl/pc_unit_if.sv
// Controller/EX-MEM signals into the PC unit and its registered state back out.
interface pc_unit_if;
  logic [1:0]  PCControl;
  logic        JumpTaken;
  logic        BranchTaken;
  logic        Call;
  logic        Return;
  logic [15:0] JumpAddr;
  logic [15:0] BranchAddr;
  logic [15:0] PC;
  logic [2:0]  StackDepth;
  logic        StackOverflow;
  logic        StackUnderflow;

  modport master (
    output PCControl, JumpTaken, BranchTaken, Call, Return, JumpAddr, BranchAddr,
    input  PC, StackDepth, StackOverflow, StackUnderflow
  );

  modport slave (
    input  PCControl, JumpTaken, BranchTaken, Call, Return, JumpAddr, BranchAddr,
    output PC, StackDepth, StackOverflow, StackUnderflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with a 4-entry circular return-address stack for jal/ret.
module pc_unit (
  input  logic     clock,
  input  logic     reset,
  pc_unit_if.slave bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned SD = 4;
  localparam int unsigned DW = 3;
  localparam int unsigned PW = 2;

  localparam logic [1:0] CTL_INC  = 2'd1;
  localparam logic [1:0] CTL_COND = 2'd2;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] stack_q [SD];
  logic [AW-1:0] stack_d [SD];
  logic [PW-1:0] top_q, top_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [PW-1:0] pop_idx;

  // top_q is the next free slot; once full it points at the oldest entry.
  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    top_d   = top_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    pop_idx = top_q - PW'(1);

    case (bus.PCControl)
      CTL_INC: pc_d = pc_q + AW'(2);
      CTL_COND: begin
        if (bus.JumpTaken && bus.Return) begin
          if (depth_q != DW'(0)) begin
            pc_d    = {stack_q[pop_idx][AW-1:1], 1'b0};
            top_d   = pop_idx;
            depth_d = depth_q - DW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end else if (bus.JumpTaken) begin
          pc_d = {bus.JumpAddr[AW-1:1], 1'b0};
          if (bus.Call) begin
            stack_d[top_q] = pc_q;
            top_d          = top_q + PW'(1);
            if (depth_q == DW'(SD)) ovf_d   = 1'b1;
            else                    depth_d = depth_q + DW'(1);
          end
        end else if (bus.BranchTaken) begin
          pc_d = {bus.BranchAddr[AW-1:1], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      top_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < SD; i++) stack_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < SD; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign bus.PC             = pc_q;
  assign bus.StackDepth     = depth_q;
  assign bus.StackOverflow  = ovf_q;
  assign bus.StackUnderflow = unf_q;
endmodule
